if_fetch_unit: RTL and testbench

- Instruction fetch stage. Owns the PC, issues in-order requests to instruction memory over a valid/ready request channel, and receives in-order responses.
- Buffers fetched instructions and presents them to the decode stage under a valid/ready handshake.
- Consumes the branch-resolution outputs of the execute stage (take-branch flag, target PC). On a redirect it flushes buffered and in-flight wrong-path instructions.

---
 rtl/if_fetch_unit_if.sv | 23 ++
 rtl/if_fetch_unit.sv | 82 ++++++++
 tb/tb_if_fetch_unit.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/if_fetch_unit_if.sv
// if_fetch_unit_if: fetch-stage bundle of redirect, imem request/response and decode handshake signals
interface if_fetch_unit_if;
  logic        ex_take_branch;
  logic [31:0] ex_target_PC;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        if_id_valid_inst;
  logic [31:0] if_id_PC;
  logic [31:0] if_id_NPC;
  logic [31:0] if_id_IR;
  logic        id_ready;
  modport master (
    input  ex_take_branch, ex_target_PC, imem_req_ready, imem_rsp_valid, imem_rsp_data, id_ready,
    output imem_req_valid, imem_req_addr, if_id_valid_inst, if_id_PC, if_id_NPC, if_id_IR
  );
  modport slave (
    output ex_take_branch, ex_target_PC, imem_req_ready, imem_rsp_valid, imem_rsp_data, id_ready,
    input  imem_req_valid, imem_req_addr, if_id_valid_inst, if_id_PC, if_id_NPC, if_id_IR
  );
endinterface

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: PC owner issuing in-order imem fetches into a small decode buffer with redirect flush
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int MAX_OUTSTANDING = 2,
  parameter int FBUF_DEPTH = 2
) (
  input logic clk,
  input logic rst,
  if_fetch_unit_if.master bus
);
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int BW = $clog2(FBUF_DEPTH + 1);
  localparam int PW = $clog2(MAX_OUTSTANDING > 1 ? MAX_OUTSTANDING : 2);
  localparam int FW = $clog2(FBUF_DEPTH > 1 ? FBUF_DEPTH : 2);
  logic [31:0] pc;
  logic [CW-1:0] live_cnt, drop_cnt;
  logic [BW-1:0] buf_cnt;
  logic [31:0] pf_mem [MAX_OUTSTANDING];
  logic [PW-1:0] pf_wr, pf_rd;
  logic [31:0] fb_pc [FBUF_DEPTH];
  logic [31:0] fb_ir [FBUF_DEPTH];
  logic [FW-1:0] fb_wr, fb_rd;
  logic acc, rsp, live_rsp, drop_rsp, pop, take;
  function automatic logic [PW-1:0] pf_next(input logic [PW-1:0] p);
    return p == PW'(MAX_OUTSTANDING - 1) ? '0 : p + PW'(1);
  endfunction
  function automatic logic [FW-1:0] fb_next(input logic [FW-1:0] p);
    return p == FW'(FBUF_DEPTH - 1) ? '0 : p + FW'(1);
  endfunction
  assign take = bus.ex_take_branch;
  assign bus.imem_req_valid = !rst && (int'(live_cnt) + int'(drop_cnt) < MAX_OUTSTANDING)
                              && (int'(live_cnt) + int'(buf_cnt) < FBUF_DEPTH);
  assign bus.imem_req_addr = rst ? (RESET_PC & ~32'd3) : (pc & ~32'd3);
  assign acc = bus.imem_req_valid && bus.imem_req_ready;
  // responses with nothing outstanding are protocol errors and are ignored
  assign rsp = bus.imem_rsp_valid && (live_cnt != '0 || drop_cnt != '0);
  assign drop_rsp = rsp && drop_cnt != '0;
  assign live_rsp = rsp && drop_cnt == '0;
  assign bus.if_id_valid_inst = !rst && buf_cnt != '0 && !take;
  assign pop = bus.if_id_valid_inst && bus.id_ready;
  assign bus.if_id_PC = bus.if_id_valid_inst ? fb_pc[fb_rd] : '0;
  assign bus.if_id_NPC = bus.if_id_valid_inst ? fb_pc[fb_rd] + 32'd4 : '0;
  assign bus.if_id_IR = bus.if_id_valid_inst ? fb_ir[fb_rd] : '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_PC;
      live_cnt <= '0;
      drop_cnt <= '0;
      buf_cnt <= '0;
      pf_wr <= '0;
      pf_rd <= '0;
      fb_wr <= '0;
      fb_rd <= '0;
    end else begin
      if (acc) begin
        pf_mem[pf_wr] <= pc;
        pf_wr <= pf_next(pf_wr);
      end
      if (rsp) pf_rd <= pf_next(pf_rd);
      // the PC FIFO survives a redirect so that wrong-path responses still retire their slot
      if (take) begin
        pc <= bus.ex_target_PC & ~32'd3;
        live_cnt <= '0;
        drop_cnt <= drop_cnt + live_cnt + CW'(acc) - CW'(rsp);
        buf_cnt <= '0;
        fb_wr <= '0;
        fb_rd <= '0;
      end else begin
        if (acc) pc <= pc + 32'd4;
        live_cnt <= live_cnt + CW'(acc) - CW'(live_rsp);
        drop_cnt <= drop_cnt - CW'(drop_rsp);
        if (live_rsp) begin
          fb_pc[fb_wr] <= pf_mem[pf_rd];
          fb_ir[fb_wr] <= bus.imem_rsp_data;
          fb_wr <= fb_next(fb_wr);
        end
        if (pop) fb_rd <= fb_next(fb_rd);
        buf_cnt <= buf_cnt + BW'(live_rsp) - BW'(pop);
      end
    end
  end
endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: directed fetch scenarios against an in-order latency memory model and a decode scoreboard
module tb_if_fetch_unit;
  typedef struct {
    logic [31:0] addr;
    int due;
  } req_t;
  logic clk = 0;
  logic rst = 1;
  int cyc = 0;
  int n_checks = 0;
  int n_pass = 0;
  int acc_cnt = 0;
  int max_out = 0;
  int lat_lo = 1;
  int lat_hi = 1;
  req_t pend[$];
  logic [31:0] exp_q[$];
  if_fetch_unit_if bus ();
  if_fetch_unit #(.RESET_PC(32'h0), .MAX_OUTSTANDING(2), .FBUF_DEPTH(2)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.master)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hDEAD_BEEF;
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, required %h", name, act, exp);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst = 1;
    tick();
    rst = 0;
  endtask
  task automatic drain(input int budget);
    int k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      tick();
      k++;
    end
    if (exp_q.size() != 0) begin
      n_checks++;
      $display("FAIL drain_timeout: %0d entries never delivered, required 0", exp_q.size());
      exp_q.delete();
    end
    bus.id_ready = 0;
  endtask
  // memory model: in-order responses, latency lat_lo..lat_hi, cleared by rst
  initial begin
    req_t r;
    int d;
    int last_due = 0;
    logic prev_stall = 0;
    logic prev_take = 0;
    logic [31:0] prev_addr = 0;
    bus.imem_rsp_valid = 0;
    bus.imem_rsp_data = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pend.delete();
        bus.imem_rsp_valid = 0;
        prev_stall = 0;
        last_due = 0;
      end else begin
        if (prev_stall && !prev_take && bus.imem_req_valid)
          chk("addr_hold", bus.imem_req_addr, prev_addr);
        if (pend.size() != 0 && pend[0].due == cyc + 1) begin
          r = pend.pop_front();
          bus.imem_rsp_valid = 1;
          bus.imem_rsp_data = mem_word(r.addr);
        end else bus.imem_rsp_valid = 0;
        if (bus.imem_req_valid && bus.imem_req_ready) begin
          d = cyc + 1 + int'($urandom_range(lat_hi, lat_lo));
          if (d <= last_due) d = last_due + 1;
          r.addr = bus.imem_req_addr;
          r.due = d;
          pend.push_back(r);
          last_due = d;
          acc_cnt++;
          if (pend.size() > max_out) max_out = pend.size();
        end
        prev_stall = bus.imem_req_valid && !bus.imem_req_ready;
        prev_addr = bus.imem_req_addr;
        prev_take = bus.ex_take_branch;
      end
    end
  end
  // decode-side monitor: every consumed head must match the next expected PC
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (bus.if_id_valid_inst && bus.id_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_pop: got PC %h, required no delivery", bus.if_id_PC);
        end else begin
          e = exp_q.pop_front();
          chk("pop_pc", bus.if_id_PC, e);
          chk("pop_ir", bus.if_id_IR, mem_word(e));
          chk("pop_npc", bus.if_id_NPC, e + 32'd4);
        end
      end
    end
  end
  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish, required finish");
    $fatal(1);
  end
  initial begin
    logic [31:0] hold;
    int a0;
    int k;
    bus.ex_take_branch = 0;
    bus.ex_target_PC = 0;
    bus.imem_req_ready = 1;
    bus.id_ready = 0;
    tick();
    tick();
    chk("rst_req_valid", 32'(bus.imem_req_valid), 0);
    chk("rst_valid_inst", 32'(bus.if_id_valid_inst), 0);
    chk("rst_addr", bus.imem_req_addr, 32'h0);
    chk("rst_pc", bus.if_id_PC, 0);
    chk("rst_ir", bus.if_id_IR, 0);
    chk("rst_npc", bus.if_id_NPC, 0);
    // stream from reset with latency 1
    for (int i = 0; i < 8; i++) exp_q.push_back(32'(i * 4));
    bus.id_ready = 1;
    rst = 0;
    #1;
    chk("first_req_valid", 32'(bus.imem_req_valid), 1);
    tick();
    chk("early_valid_inst", 32'(bus.if_id_valid_inst), 0);
    chk("second_addr", bus.imem_req_addr, 32'h4);
    tick();
    chk("first_valid_inst", 32'(bus.if_id_valid_inst), 1);
    chk("first_pc", bus.if_id_PC, 32'h0);
    drain(200);
    // decode stall: two fetches fill the buffer and the head holds
    do_reset();
    a0 = acc_cnt;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (i == 4 || i == 9) begin
        chk("stall_valid", 32'(bus.if_id_valid_inst), 1);
        chk("stall_pc", bus.if_id_PC, 32'h0);
        chk("stall_ir", bus.if_id_IR, mem_word(32'h0));
      end
    end
    chk("stall_req_count", 32'(acc_cnt - a0), 2);
    chk("stall_addr", bus.imem_req_addr, 32'h8);
    chk("stall_req_valid", 32'(bus.imem_req_valid), 0);
    for (int i = 0; i < 5; i++) exp_q.push_back(32'(i * 4));
    bus.id_ready = 1;
    drain(200);
    // redirect with 0x8/0xC in flight
    lat_lo = 3;
    lat_hi = 3;
    exp_q = '{32'h0, 32'h4, 32'h100, 32'h104, 32'h108, 32'h10C};
    bus.id_ready = 1;
    do_reset();
    k = 0;
    while (!(pend.size() == 2 && pend[0].addr == 32'h8 && pend[1].addr == 32'hC) && k < 100) begin
      tick();
      k++;
    end
    if (k >= 100) begin
      n_checks++;
      $display("FAIL inflight_timeout: got %0d pending, required 0x8/0xC in flight", pend.size());
    end
    bus.ex_take_branch = 1;
    bus.ex_target_PC = 32'h100;
    #1;
    chk("redirect_mask", 32'(bus.if_id_valid_inst), 0);
    tick();
    bus.ex_take_branch = 0;
    #1;
    chk("redirect_addr", bus.imem_req_addr, 32'h100);
    chk("redirect_drop_block", 32'(bus.imem_req_valid), 0);
    drain(200);
    // redirect coinciding with an accepted request and a live response
    lat_lo = 1;
    lat_hi = 1;
    exp_q = '{32'h200, 32'h204, 32'h208, 32'h20C};
    bus.id_ready = 1;
    do_reset();
    tick();
    bus.ex_take_branch = 1;
    bus.ex_target_PC = 32'h202;
    tick();
    bus.ex_take_branch = 0;
    #1;
    chk("same_cycle_addr", bus.imem_req_addr, 32'h200);
    chk("same_cycle_req_valid", 32'(bus.imem_req_valid), 1);
    drain(200);
    // memory backpressure with random latency
    lat_lo = 1;
    lat_hi = 4;
    for (int i = 0; i < 16; i++) exp_q.push_back(32'(i * 4));
    bus.id_ready = 1;
    do_reset();
    repeat (6) tick();
    bus.imem_req_ready = 0;
    hold = bus.imem_req_addr;
    repeat (5) tick();
    chk("ready_low_addr", bus.imem_req_addr, hold);
    bus.imem_req_ready = 1;
    drain(400);
    // reset mid-stream with a full buffer
    repeat (8) tick();
    chk("full_valid", 32'(bus.if_id_valid_inst), 1);
    chk("full_head_pc", bus.if_id_PC, 32'h40);
    rst = 1;
    tick();
    chk("midrst_req_valid", 32'(bus.imem_req_valid), 0);
    chk("midrst_valid_inst", 32'(bus.if_id_valid_inst), 0);
    chk("midrst_addr", bus.imem_req_addr, 32'h0);
    chk("midrst_pc", bus.if_id_PC, 0);
    chk("midrst_ir", bus.if_id_IR, 0);
    chk("midrst_npc", bus.if_id_NPC, 0);
    rst = 0;
    #1;
    chk("resume_valid_inst", 32'(bus.if_id_valid_inst), 0);
    chk("resume_req_valid", 32'(bus.imem_req_valid), 1);
    chk("resume_addr", bus.imem_req_addr, 32'h0);
    exp_q = '{32'h0, 32'h4, 32'h8, 32'hC};
    bus.id_ready = 1;
    drain(200);
    chk("max_outstanding_le_2", 32'(max_out <= 2), 1);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
